// File: rtl/count_scheduler.sv
// count_scheduler: round-robin owner of one shared count_machine.
// Watchdog abort is built only with `define COUNT_SCHED_TIMEOUT_EN.
module count_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int GAP_TICKS     = 1,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_enable,
    input  logic [NUM_REQ-1:0] req,
    input  logic               cm_last,
    output logic               cm_start,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic               busy,
    output logic               timeout
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, START, RUN, GAP} state_t;

    state_t             state;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      win_idx;
    logic               win_vld;
    logic [NUM_REQ-1:0] win_oh;
    logic [PW:0]        scan_sum;
    logic [7:0]         gap_cnt;
    logic               tmo_hit;
    logic               run_end;

    // Scan from rr_ptr upward; descending loop leaves the nearest hit.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_sum = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_sum = {1'b0, rr_ptr} + (PW+1)'(i);
            if (scan_sum >= (PW+1)'(NUM_REQ))
                scan_sum = scan_sum - (PW+1)'(NUM_REQ);
            if (req[scan_sum[PW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = scan_sum[PW-1:0];
            end
        end
    end

    assign win_oh = NUM_REQ'(1) << win_idx;

`ifdef COUNT_SCHED_TIMEOUT_EN
    logic [15:0] tick_cnt;

    assign tmo_hit = clk_enable && !cm_last &&
                     (tick_cnt == 16'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst)
            tick_cnt <= '0;
        else if (state == START && clk_enable)
            tick_cnt <= '0;
        else if (state == RUN && clk_enable)
            tick_cnt <= tick_cnt + 16'd1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign run_end = cm_last || tmo_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            done     <= '0;
            cm_start <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            gap_cnt  <= '0;
        end else begin
            done    <= '0;
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant    <= win_oh;
                        rr_ptr   <= (win_idx == PW'(NUM_REQ - 1)) ?
                                    '0 : win_idx + PW'(1);
                        cm_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (clk_enable) begin
                        cm_start <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (run_end) begin
                        done    <= cm_last ? grant : '0;
                        timeout <= tmo_hit;
                        grant   <= '0;
                        gap_cnt <= '0;
                        if (GAP_TICKS == 0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (clk_enable) begin
                        if (gap_cnt == 8'(GAP_TICKS - 1)) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= '0;
                    cm_start <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_scheduler.sv
// tb_count_scheduler: vector table, hand sequences and random
// transactions against a transaction-level round-robin model.
module tb_count_scheduler;

    localparam int GAP = 1;
`ifdef COUNT_SCHED_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_enable;
    logic [3:0] req;
    logic       cm_last;
    logic       cm_start;
    logic [3:0] grant;
    logic [3:0] done;
    logic       busy;
    logic       timeout;

    int total = 0;
    int bad   = 0;
    int len_cfg = 4;
    bit no_last = 1'b0;
    int cyc_cnt = 0;
    logic cm_act = 1'b0;
    int   cm_cnt = 0;

    typedef struct {
        logic [3:0] req;
        int         len;
        int         drop;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    count_scheduler #(
        .NUM_REQ(4),
        .GAP_TICKS(GAP),
        .TIMEOUT_TICKS(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clk_enable(clk_enable),
        .req(req),
        .cm_last(cm_last),
        .cm_start(cm_start),
        .grant(grant),
        .done(done),
        .busy(busy),
        .timeout(timeout)
    );

    // Environment: a counter of len_cfg values started by cm_start.
    always @(posedge clk) begin
        if (rst) begin
            cm_act <= 1'b0;
        end else if (clk_enable) begin
            if (cm_start) begin
                cm_act <= 1'b1;
                cm_cnt <= 0;
            end else if (cm_act) begin
                if (cm_cnt == len_cfg - 1) cm_act <= 1'b0;
                else cm_cnt <= cm_cnt + 1;
            end
        end
    end

    assign cm_last = cm_act && (cm_cnt == len_cfg - 1) && !no_last;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_en(input int mode, output bit e);
        cyc_cnt++;
        case (mode)
            0: e = 1'b1;
            1: e = 1'($urandom_range(0, 1));
            default: e = (cyc_cnt % 4 == 0);
        endcase
        clk_enable = e;
    endtask

    task automatic wait_grant(input int mode, output int lat);
        bit e;
        lat = 0;
        while (lat < 100 && grant == 4'b0000) begin
            set_en(mode, e);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst = 1'b1;
        req = r;
        clk_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_grant", grant, 0);
            chk("rst_start", cm_start, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_tmo", timeout, 0);
        end
        rst = 1'b0;
    endtask

    task automatic run_txn(input logic [3:0] r, input int len,
                           input int mode, input int drop_at,
                           input logic [3:0] exp_g, input string nm,
                           output int lat);
        bit e, started, got;
        logic [3:0] g;
        int rticks, gticks, n;
        req = r;
        len_cfg = len;
        wait_grant(mode, lat);
        chk({nm, "_grant"}, grant, exp_g);
        if (grant == 4'b0000) return;
        chk({nm, "_start1"}, cm_start, 1);
        chk({nm, "_busy1"}, busy, 1);
        g = grant;
        started = 1'b0;
        rticks = 0;
        got = 1'b0;
        for (n = 0; n < 200 && !got; n++) begin
            if (n == drop_at) req = 4'b0000;
            set_en(mode, e);
            @(negedge clk);
            if (done != 4'b0000) begin
                got = 1'b1;
            end else if (!started) begin
                chk({nm, "_hold"}, cm_start, !e);
                started = !cm_start;
            end else if (e) begin
                rticks++;
            end
        end
        if (drop_at >= 0) req = 4'b0000;
        chk({nm, "_done"}, done, g);
        chk({nm, "_order"}, started, 1);
        chk({nm, "_runlen"}, rticks, len - 1);
        chk({nm, "_gclr"}, grant, 0);
        chk({nm, "_tmo"}, timeout, 0);
        gticks = 0;
        got = (busy == 1'b0);
        for (n = 0; n < 200 && !got; n++) begin
            set_en(mode, e);
            @(negedge clk);
            if (n == 0) chk({nm, "_pulse"}, done, 0);
            if (e) gticks++;
            if (busy == 1'b0) got = 1'b1;
        end
        chk({nm, "_gap"}, gticks, GAP);
    endtask

`ifdef COUNT_SCHED_TIMEOUT_EN
    task automatic tmo_test();
        bit e, started, got;
        int ticks, lat;
        no_last = 1'b1;
        req = 4'b0010;
        wait_grant(0, lat);
        chk("tmo_grant", grant, 4'b0010);
        req = 4'b0000;
        started = 1'b0;
        got = 1'b0;
        ticks = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            set_en(0, e);
            @(negedge clk);
            chk("tmo_nodone", done, 0);
            if (timeout) begin
                got = 1'b1;
                if (e) ticks++;
            end else if (!started) begin
                started = !cm_start;
            end else if (e) begin
                ticks++;
            end
        end
        chk("tmo_fired", got, 1);
        chk("tmo_ticks", ticks, TMO);
        chk("tmo_gclr", grant, 0);
        @(negedge clk);
        chk("tmo_pulse", timeout, 0);
        for (int n = 0; n < 50 && busy; n++) @(negedge clk);
        chk("tmo_idle", busy, 0);
        no_last = 1'b0;
        run_txn(4'b0001, 2, 0, 0, 4'b0001, "after_tmo", lat);
    endtask
`endif

    initial begin
        logic [3:0] r;
        int ln, dr, w, mptr, lat;

        tbl[0]  = '{4'b1011, 4, -1, 4'b0001};
        tbl[1]  = '{4'b1011, 4, -1, 4'b0010};
        tbl[2]  = '{4'b1011, 4, -1, 4'b1000};
        tbl[3]  = '{4'b1011, 4, -1, 4'b0001};
        tbl[4]  = '{4'b0100, 1,  0, 4'b0100};
        tbl[5]  = '{4'b0011, 2, -1, 4'b0001};
        tbl[6]  = '{4'b1111, 3,  0, 4'b0010};
        tbl[7]  = '{4'b1001, 1, -1, 4'b1000};
        tbl[8]  = '{4'b0110, 2,  0, 4'b0010};
        tbl[9]  = '{4'b0010, 4, -1, 4'b0010};
        tbl[10] = '{4'b1100, 1,  0, 4'b0100};
        tbl[11] = '{4'b0101, 3,  0, 4'b0001};

        rst = 1'b1;
        req = 4'b0000;
        clk_enable = 1'b1;

        do_reset(4'b1111);
        run_txn(4'b1111, 4, 0, 0, 4'b0001, "first", lat);
        chk("first_lat", lat, 1);

        do_reset(4'b0000);
        foreach (tbl[i])
            run_txn(tbl[i].req, tbl[i].len, 0, tbl[i].drop,
                    tbl[i].exp, "rr", lat);

        run_txn(4'b0100, 4, 0, 3, 4'b0100, "drop", lat);

        req = 4'b0100;
        len_cfg = 4;
        wait_grant(0, lat);
        chk("mr_grant", grant, 4'b0100);
        @(negedge clk);
        @(negedge clk);
        req = 4'b0000;
        rst = 1'b1;
        @(negedge clk);
        chk("mr_gclr", grant, 0);
        chk("mr_done", done, 0);
        chk("mr_busy", busy, 0);
        chk("mr_start", cm_start, 0);
        rst = 1'b0;
        run_txn(4'b1111, 2, 0, 0, 4'b0001, "mr_ptr", lat);

        run_txn(4'b1000, 3, 2, 0, 4'b1000, "gate", lat);

`ifdef COUNT_SCHED_TIMEOUT_EN
        tmo_test();
`endif

        do_reset(4'b0000);
        mptr = 0;
        for (int t = 0; t < 30; t++) begin
            r  = 4'($urandom_range(1, 15));
            ln = $urandom_range(1, 4);
            dr = $urandom_range(0, 4) - 1;
            w  = 0;
            for (int k = 3; k >= 0; k--)
                if (((r >> ((mptr + k) % 4)) & 4'b0001) != 0)
                    w = (mptr + k) % 4;
            run_txn(r, ln, 1, dr, 4'(1 << w), "rnd", lat);
            mptr = (w + 1) % 4;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
